// File: rtl/bus_phase_pkg.sv
// -----------------------------------------------------------------------------
// bus_phase_pkg
// Shared types and defaults for the bus phase generator.
//   speed_t    : phase-length divisor exponent (L = BASE_DIV >> speed, min 1)
//   DEF_*      : default values for the bus_phase_gen parameters
//   LEN_W      : width able to hold a phase length of 1..64 clk32 cycles
//   phase_len(): clamped phase length for a given base divider and speed
// -----------------------------------------------------------------------------
package bus_phase_pkg;

  typedef enum logic [1:0] {
    SPD_1X = 2'd0,
    SPD_2X = 2'd1,
    SPD_4X = 2'd2,
    SPD_8X = 2'd3
  } speed_t;

  localparam int DEF_PHASES      = 8;
  localparam int DEF_BASE_DIV    = 2;
  localparam int DEF_LATCH_PHASE = 5;
  localparam int DEF_HOLD_PHASE  = 3;

  localparam int LEN_W = 7;

  // Faster speeds shorten the phase; a base divider smaller than the shift
  // would give zero, which is clamped to a single clk32 cycle per phase.
  function automatic logic [LEN_W-1:0] phase_len(input int base_div, input speed_t spd);
    int l;
    l = base_div >> spd;
    return (l < 1) ? LEN_W'(1) : LEN_W'(l);
  endfunction

endpackage

// File: rtl/bus_phase_div.sv
// -----------------------------------------------------------------------------
// bus_phase_div
// Phase-length counter. Counts 0..len-1 and signals an advance on the final
// count. A stall freezes the counter on its final count so the phase is
// stretched until the stall drops.
//   clk32   in  : clock
//   resb    in  : asynchronous active-low reset
//   len     in  : phase length in clk32 cycles (1..64)
//   stall   in  : hold the final count instead of advancing
//   last    out : counter is on the final count of the phase
//   advance out : phase advances on the next clk32 edge
// -----------------------------------------------------------------------------
module bus_phase_div
  import bus_phase_pkg::*;
(
  input  logic             clk32,
  input  logic             resb,
  input  logic [LEN_W-1:0] len,
  input  logic             stall,
  output logic             last,
  output logic             advance
);

  logic [LEN_W-2:0] count;

  // ">=" keeps the counter from running away should len ever shrink under it.
  assign last    = ({1'b0, count} >= (len - LEN_W'(1)));
  assign advance = last & ~stall;

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      count <= '0;
    end else if (advance) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in the design samples the values from before the clock edge.
      count <= '0;
    end else if (!last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_phase_gen.sv
// -----------------------------------------------------------------------------
// bus_phase_gen
// Generates the phase sequence of a bus cycle from the fast clk32, together
// with the bus clock level, its edge enables and the per-phase strobes.
// Optional hold stretching is compiled in with the macro BUS_PHASE_HOLD_EN;
// without it the hold input is ignored and stalled is tied low.
//   clk32        in  : sole clock
//   resb         in  : asynchronous active-low reset
//   speed[1:0]   in  : requested divisor exponent, taken at the cycle wrap
//   hold         in  : stretch request for HOLD_PHASE
//   phase        out : one-hot current phase
//   phase_idx    out : binary current phase
//   phase_en     out : pulse in the first clk32 cycle of each phase
//   cycle_start  out : pulse at the start of phase 0
//   latch        out : pulse at the start of LATCH_PHASE
//   busclk       out : bus clock level, high in the first half of the cycle
//   busclk_en_p  out : clk32 cycle before busclk rises
//   busclk_en_n  out : clk32 cycle before busclk falls
//   stalled      out : a hold is currently extending HOLD_PHASE
//   speed_cur    out : speed in force for the current bus cycle
// -----------------------------------------------------------------------------
module bus_phase_gen
  import bus_phase_pkg::*;
#(
  parameter int PHASES      = DEF_PHASES,
  parameter int BASE_DIV    = DEF_BASE_DIV,
  parameter int LATCH_PHASE = DEF_LATCH_PHASE,
  parameter int HOLD_PHASE  = DEF_HOLD_PHASE
) (
  input  logic                      clk32,
  input  logic                      resb,
  input  logic [1:0]                speed,
  input  logic                      hold,
  output logic [PHASES-1:0]         phase,
  output logic [$clog2(PHASES)-1:0] phase_idx,
  output logic                      phase_en,
  output logic                      cycle_start,
  output logic                      latch,
  output logic                      busclk,
  output logic                      busclk_en_p,
  output logic                      busclk_en_n,
  output logic                      stalled,
  output logic [1:0]                speed_cur
);

  localparam int IDX_W = $clog2(PHASES);
  localparam int HALF  = PHASES / 2;

  logic [LEN_W-1:0] len;
  logic             last;
  logic             advance;
  logic             stall;
  logic             is_last_phase;
  logic [IDX_W-1:0] next_idx;

  assign len           = phase_len(BASE_DIV, speed_t'(speed_cur));
  assign is_last_phase = (phase_idx == IDX_W'(PHASES - 1));
  assign next_idx      = is_last_phase ? '0 : phase_idx + 1'b1;

`ifdef BUS_PHASE_HOLD_EN
  // Only a hold seen on the final count of HOLD_PHASE stretches the phase.
  assign stall = hold & last & (phase_idx == IDX_W'(HOLD_PHASE));
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign stall       = 1'b0;
`endif

  bus_phase_div u_div (
    .clk32   (clk32),
    .resb    (resb),
    .len     (len),
    .stall   (stall),
    .last    (last),
    .advance (advance)
  );

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      phase_idx <= '0;
      phase     <= {{(PHASES-1){1'b0}}, 1'b1};
      busclk    <= 1'b1;
      phase_en  <= 1'b0;
      speed_cur <= 2'd0;
    end else begin
      // Registered so it marks the first cycle of the phase just entered.
      phase_en <= advance;
      if (advance) begin
        phase_idx <= next_idx;
        phase     <= {{(PHASES-1){1'b0}}, 1'b1} << next_idx;
        busclk    <= (next_idx < IDX_W'(HALF));
        // Speed is only picked up at the wrap so a bus cycle never changes
        // its phase length part way through.
        if (is_last_phase) begin
          speed_cur <= speed;
        end
      end
    end
  end

  assign cycle_start = phase_en & (phase_idx == '0);
  assign latch       = phase_en & (phase_idx == IDX_W'(LATCH_PHASE));
  // Tied to advance, so a stalled phase can never raise a bus clock enable.
  assign busclk_en_p = advance & is_last_phase;
  assign busclk_en_n = advance & (phase_idx == IDX_W'(HALF - 1));
  assign stalled     = stall;

endmodule

// File: tb/tb_bus_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_bus_phase_gen
// Scoreboard bench for bus_phase_gen with default parameters. The stimulus
// process pushes the expected shape of each bus cycle it drives; the monitor
// measures every window between consecutive cycle_start pulses and compares.
// -----------------------------------------------------------------------------
module tb_bus_phase_gen;

  logic       clk32 = 1'b0;
  logic       resb  = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       hold  = 1'b0;

  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       phase_en, cycle_start, latch, busclk;
  logic       busclk_en_p, busclk_en_n, stalled;
  logic [1:0] speed_cur;

  bus_phase_gen dut (
    .clk32       (clk32),
    .resb        (resb),
    .speed       (speed),
    .hold        (hold),
    .phase       (phase),
    .phase_idx   (phase_idx),
    .phase_en    (phase_en),
    .cycle_start (cycle_start),
    .latch       (latch),
    .busclk      (busclk),
    .busclk_en_p (busclk_en_p),
    .busclk_en_n (busclk_en_n),
    .stalled     (stalled),
    .speed_cur   (speed_cur)
  );

  always #5 clk32 = ~clk32;

  typedef struct {
    int len;   // clk32 cycles from cycle_start to next cycle_start
    int lat;   // offset of latch from cycle_start
    int hi;    // cycles with busclk high
    int pe;    // cycles with phase_en high
    int st;    // cycles with stalled high
    int enp;   // busclk_en_p pulses
    int enn;   // busclk_en_n pulses
    int sten;  // enable pulses while stalled
    int spd;   // speed_cur at cycle_start
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_push = 0;
  int   n_pop = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  function automatic exp_t mk(int len, int lat, int hi, int pe, int st,
                              int enp, int enn, int sten, int spd);
    exp_t e;
    e.len = len; e.lat = lat; e.hi = hi; e.pe = pe; e.st = st;
    e.enp = enp; e.enn = enn; e.sten = sten; e.spd = spd;
    return e;
  endfunction

  // Monitor: one window per bus cycle, delimited by cycle_start.
  initial begin : monitor
    bit   have;
    int   w_len, w_lat, w_hi, w_pe, w_st, w_enp, w_enn, w_sten, w_spd;
    exp_t e;
    have = 1'b0;
    w_len = 0; w_lat = -1; w_hi = 0; w_pe = 0; w_st = 0;
    w_enp = 0; w_enn = 0; w_sten = 0; w_spd = 0;
    forever begin
      @(negedge clk32);
      if (!resb) begin
        have = 1'b0;
      end else begin
        if (cycle_start) begin
          if (have) begin
            if (exp_q.size() == 0) begin
              check("sb_underflow", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              n_pop++;
              check("cycle_len",      w_len,  e.len);
              check("latch_offset",   w_lat,  e.lat);
              check("busclk_hi",      w_hi,   e.hi);
              check("phase_en_count", w_pe,   e.pe);
              check("stalled_count",  w_st,   e.st);
              check("en_p_count",     w_enp,  e.enp);
              check("en_n_count",     w_enn,  e.enn);
              check("en_in_stall",    w_sten, e.sten);
              check("speed_cur",      w_spd,  e.spd);
            end
          end
          have = 1'b1;
          w_len = 0; w_lat = -1; w_hi = 0; w_pe = 0; w_st = 0;
          w_enp = 0; w_enn = 0; w_sten = 0; w_spd = int'(speed_cur);
        end
        if (have) begin
          w_len++;
          if (latch)        w_lat = w_len - 1;
          if (busclk)       w_hi++;
          if (phase_en)     w_pe++;
          if (stalled)      w_st++;
          if (busclk_en_p)  w_enp++;
          if (busclk_en_n)  w_enn++;
          if (stalled && (busclk_en_p || busclk_en_n)) w_sten++;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_phase_idx"}, int'(phase_idx), 0);
    check({tag, "_phase"},     int'(phase), 1);
    check({tag, "_busclk"},    int'(busclk), 1);
    check({tag, "_stalled"},   int'(stalled), 0);
    check({tag, "_speed_cur"}, int'(speed_cur), 0);
    check({tag, "_pulses"},
          int'({phase_en, cycle_start, latch, busclk_en_p, busclk_en_n}), 0);
  endtask

  // Called just after resb is released; returns on the first cycle_start sample.
  task automatic startup();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk32);
      n++;
      @(negedge clk32);
      if (n == 1)
        check("no_early_pulse",
              int'({phase_en, cycle_start, latch, busclk_en_p, busclk_en_n}), 0);
      seen = cycle_start;
    end
    check("first_start_delay", n, 16);
    if (!seen) finish_up();
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      @(negedge clk32);
      n++;
    end while (!cycle_start && n < 64);
    check("cycle_start_seen", int'(cycle_start), 1);
    if (!cycle_start) finish_up();
  endtask

  // Entered on a cycle_start sample; drives one bus cycle and returns on the
  // next cycle_start sample.
  task automatic run_cycle(input exp_t e, input bit chg, input logic [1:0] spd_new,
                           input bit do_hold);
    int steps;
    exp_q.push_back(e);
    n_push++;
    steps = do_hold ? 12 : (chg ? 2 : 0);
    for (int i = 1; i <= steps; i++) begin
      @(posedge clk32);
      #1;
      if (do_hold && i == 1)  hold  = 1'b1;
      if (do_hold && i == 12) hold  = 1'b0;
      if (chg && i == 2)      speed = spd_new;
    end
    wait_start();
  endtask

  initial begin : watchdog
    #100000;
    n_total++;
    $display("FAIL watchdog: time limit reached before completion, expected finish");
    finish_up();
  end

  initial begin : stimulus
    repeat (2) @(posedge clk32);
    #1;
    check_reset_values("por");
    resb = 1'b1;
    startup();

    // Speed requests land mid-cycle and only take effect at the following wrap.
    run_cycle(mk(16, 10, 8, 8, 0, 1, 1, 0, 0), 1'b1, 2'd1, 1'b0);
    run_cycle(mk( 8,  5, 4, 8, 0, 1, 1, 0, 1), 1'b1, 2'd3, 1'b0);
    run_cycle(mk( 8,  5, 4, 8, 0, 1, 1, 0, 3), 1'b1, 2'd2, 1'b0);
    run_cycle(mk( 8,  5, 4, 8, 0, 1, 1, 0, 2), 1'b1, 2'd0, 1'b0);

`ifdef BUS_PHASE_HOLD_EN
    // hold raised early (ignored) and kept for 5 final-count cycles of phase 3.
    run_cycle(mk(21, 15, 13, 8, 5, 1, 1, 0, 0), 1'b0, 2'd0, 1'b1);
`else
    run_cycle(mk(16, 10, 8, 8, 0, 1, 1, 0, 0), 1'b0, 2'd0, 1'b1);
    hold = 1'b1;
    run_cycle(mk(16, 10, 8, 8, 0, 1, 1, 0, 0), 1'b0, 2'd0, 1'b0);
`endif

    run_cycle(mk(16, 10, 8, 8, 0, 1, 1, 0, 0), 1'b1, 2'd1, 1'b0);

    // Fast cycle interrupted by reset in phase 6; no expectation is queued.
    check("pre_rst_speed_cur", int'(speed_cur), 1);
    repeat (6) @(posedge clk32);
    #1;
    check("pre_rst_phase_idx", int'(phase_idx), 6);
    resb  = 1'b0;
    speed = 2'd0;
    #1;
    check_reset_values("mid");
    repeat (2) @(posedge clk32);
    #1;
    resb = 1'b1;
    startup();

    run_cycle(mk(16, 10, 8, 8, 0, 1, 1, 0, 0), 1'b0, 2'd0, 1'b0);

    @(posedge clk32);
    #1;
    check("sb_drained", exp_q.size(), 0);
    check("sb_pops", n_pop, n_push);
    finish_up();
  end

endmodule

// File: doc/bus_phase_gen.md
BUS_PHASE_GEN -- requirements
Module: bus_phase_gen

Interface
REQ-001 SHALL have parameter PHASES, default 8, phases per bus cycle (even, 4..16).
REQ-002 SHALL have parameter BASE_DIV, default 2, clk32 cycles per phase at speed 0 (power of two, 1..64).
REQ-003 SHALL have parameter LATCH_PHASE, default 5, phase index whose start raises latch (0..PHASES-1).
REQ-004 SHALL have parameter HOLD_PHASE, default 3, phase index that hold may stretch (0..PHASES-1).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk32 (input, 1, sole clock) and resb (input, 1, async active-low reset).
REQ-006 speed  input  2  requested phase-length divisor exponent.
REQ-007 hold  input  1  stretch request for HOLD_PHASE.
REQ-008 phase  output  PHASES  one-hot current phase.
REQ-009 phase_idx  output  clog2(PHASES)  binary current phase.
REQ-010 phase_en  output  1  one-cycle pulse in first clk32 cycle of each phase.
REQ-011 cycle_start, latch  output  1 each  one-cycle pulses at phase 0 start and LATCH_PHASE start.
REQ-012 busclk  output  1  bus clock level, high in phases 0..PHASES/2-1.
REQ-013 busclk_en_p, busclk_en_n  output  1 each  one-cycle enables in the clk32 cycle before busclk rises / falls.
REQ-014 stalled  output  1  high while a hold is extending HOLD_PHASE.
REQ-015 speed_cur  output  2  speed value in force for the current bus cycle.

Function
REQ-016 Phase length L SHALL be max(1, BASE_DIV >> speed_cur) clk32 cycles.
REQ-017 Divider count SHALL run 0..L-1; on count L-1 the phase SHALL advance and the count SHALL return to 0; phase PHASES-1 SHALL wrap to 0.
REQ-018 phase, phase_idx, busclk SHALL be registered and change on the clk32 edge that advances the phase.
REQ-019 phase_en SHALL be high exactly when count==0 following an advance; cycle_start = phase_en & phase_idx==0; latch = phase_en & phase_idx==LATCH_PHASE.
REQ-020 busclk_en_p SHALL be high on the final count of phase PHASES-1 when advancing; busclk_en_n on the final count of phase PHASES/2-1 when advancing.
REQ-021 speed SHALL be sampled only on the advance from PHASES-1 to 0 and loaded into speed_cur on that edge; mid-cycle changes SHALL have no effect.
REQ-022 When L==1 every clk32 cycle is an advance; phase_en SHALL then be continuously high.
REQ-023 Hold (when compiled in): on final count of HOLD_PHASE with hold=1, phase SHALL not advance, count SHALL stay L-1, stalled SHALL be 1; first cycle with hold=0 SHALL advance.
REQ-024 During a hold, busclk_en_p/en_n SHALL not assert; busclk SHALL keep its level.
REQ-025 hold sampled outside the final count of HOLD_PHASE SHALL be ignored.

Reset
REQ-026 resb low SHALL asynchronously set count=0, phase_idx=0, phase=1, speed_cur=0, busclk=1, stalled=0, all pulse outputs 0.
REQ-027 After resb release, first advance SHALL occur L(speed 0) cycles later; no pulse SHALL assert before it.
REQ-028 Reset mid-cycle or mid-hold SHALL abandon the cycle; no partial pulse SHALL follow release.

Configuration
REQ-029 Macro BUS_PHASE_HOLD_EN defined: REQ-023..REQ-025 in force.
REQ-030 Macro BUS_PHASE_HOLD_EN undefined: hold port present but ignored, stalled tied 0, no stretch logic synthesised.

Structure
REQ-031 Package bus_phase_pkg SHALL hold speed_t typedef (SPD_1X, SPD_2X, SPD_4X, SPD_8X) and default parameter constants.
REQ-032 Sub-module bus_phase_div SHALL implement the phase-length counter (inputs L, stall; output advance).

Verification
REQ-033 Defaults, speed=0, no hold: cycle = 16 clk32; cycle_start every 16; latch 10 cycles after cycle_start; busclk high 8, low 8.
REQ-034 speed 0->1 driven mid-cycle: current cycle stays 16 clk32, next cycle 8 clk32, speed_cur changes on the wrap edge.
REQ-035 BASE_DIV=2, speed=3: L clamps to 1; phase_en constantly 1; cycle = 8 clk32.
REQ-036 hold=1 for 5 cycles at final count of phase 3: cycle = 21 clk32; stalled high 5 cycles; no busclk_en pulse during stall.
REQ-037 resb pulsed low in phase 6: outputs to reset values immediately; first cycle_start 16 clk32 after release.
REQ-038 Build without BUS_PHASE_HOLD_EN, hold=1 permanently: cycle stays 16 clk32, stalled 0.
